// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, idle line level and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic UART_IDLE_LVL   = 1'b1;
  localparam int   UART_OVERSAMPLE = 16;
  localparam int   UART_DATA_BITS  = 8;

  // Even parity over the payload: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, mid-bit sampling, LSB-first payload, one-clk result pulses.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | confirming the start bit at its mid-point
// DATA   | sampling payload bits at mid-bit
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit and publishing the result
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_s;
  logic                 rx_prev;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_err_q;
  assign parity_err = par_err_q;
`else
  assign parity_err = 1'b0;
`endif

  uart_sync2 #(
    .RESET_VAL(UART_IDLE_LVL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_prev     <= UART_IDLE_LVL;
      data_out    <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      valid       <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      if (tick) begin
        // rx_prev tracks the line in every state so a line left low after a frame never looks like an edge
        rx_prev <= rx_s;
        case (state)
          IDLE: begin
            if (rx_prev && !rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shift    <= DATA_BITS'({rx_s, shift} >> 1);
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                state   <= PARITY;
`else
                state   <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rx_s;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (!rx_s) begin
                framing_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (^{shift, par_bit}) begin
                par_err_q <= 1'b1;
`endif
              end else begin
                valid    <= 1'b1;
                data_out <= shift;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       framing_err;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  int unsigned cyc = 0;
  logic [7:0]  vq[$];
  int unsigned vt[$];
  int          fcnt = 0;
  int          pcnt = 0;
  int          excl = 0;
  logic        busy_mid;
  int unsigned start_cyc;

  uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .busy       (busy),
    .framing_err(framing_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      cyc  = cyc + 1;
      tick = (cyc % 4 == 0);
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(data_out);
      vt.push_back(cyc);
    end
    if (framing_err) fcnt++;
    if (parity_err) pcnt++;
    if (int'(valid) + int'(framing_err) + int'(parity_err) > 1) excl++;
  end

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic clear_mon();
    vq.delete();
    vt.delete();
    fcnt = 0;
    pcnt = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    start_cyc = cyc;
    send_bit(1'b0);
    busy_mid = busy;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bz) rx = 1'b1;
`endif
    send_bit(stop);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(5);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (framing_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", framing_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err); end
    reset = 1'b0;
    wait_clk(2 * BIT_CLK);
  endtask

  task automatic test_basic();
    int unsigned lat;
    clear_mon();
    send_frame(8'hA5, 1'b1, even_par(8'hA5));
    wait_clk(2 * BIT_CLK);
    total++; if (vq.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", vq.size()); end
    if (vq.size() >= 1) begin
      total++; if (vq[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", vq[0]); end
      lat = vt[0] - start_cyc;
      total++; if (lat < 605 || lat > 620) begin bad++; $display("FAIL basic_latency got=%0d want=605..620", lat); end
    end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL basic_hold got=%h want=a5", data_out); end
    total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL basic_busy_mid got=%b want=1", busy_mid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    total++; if (fcnt != 0) begin bad++; $display("FAIL basic_ferr got=%0d want=0", fcnt); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    wait_clk(12);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_during got=%b want=1", busy); end
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    total++; if (vq.size() != 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", vq.size()); end
    total++; if (fcnt != 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", fcnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_after got=%b want=0", busy); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL glitch_hold got=%h want=a5", data_out); end
  endtask

  task automatic test_framing();
    clear_mon();
    send_frame(8'h3C, 1'b0, even_par(8'h3C));
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    total++; if (fcnt != 1) begin bad++; $display("FAIL framing_count got=%0d want=1", fcnt); end
    total++; if (vq.size() != 0) begin bad++; $display("FAIL framing_valid got=%0d want=0", vq.size()); end
    total++; if (pcnt != 0) begin bad++; $display("FAIL framing_perr got=%0d want=0", pcnt); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL framing_hold got=%h want=a5", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL framing_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h00, 1'b1, even_par(8'h00));
    send_frame(8'hFF, 1'b1, even_par(8'hFF));
    wait_clk(2 * BIT_CLK);
    total++; if (vq.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", vq.size()); end
    if (vq.size() >= 2) begin
      total++; if (vq[0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", vq[0]); end
      total++; if (vq[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", vq[1]); end
    end
    total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL b2b_hold got=%h want=ff", data_out); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    rx = 1'b1;
    wait_clk(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", data_out); end
    wait_clk(10);
    reset = 1'b0;
    wait_clk(2 * BIT_CLK);
    total++; if (vq.size() != 0 || fcnt != 0) begin bad++; $display("FAIL rstmid_spurious got=%0d/%0d want=0/0", vq.size(), fcnt); end
    send_frame(8'h81, 1'b1, even_par(8'h81));
    wait_clk(2 * BIT_CLK);
    total++; if (vq.size() != 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", vq.size()); end
    if (vq.size() >= 1) begin
      total++; if (vq[0] !== 8'h81) begin bad++; $display("FAIL rstmid_frame got=%h want=81", vq[0]); end
    end
    total++; if (data_out !== 8'h81) begin bad++; $display("FAIL rstmid_hold got=%h want=81", data_out); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clk(2 * BIT_CLK);
    total++; if (pcnt != 1) begin bad++; $display("FAIL parity_bad_perr got=%0d want=1", pcnt); end
    total++; if (vq.size() != 0) begin bad++; $display("FAIL parity_bad_valid got=%0d want=0", vq.size()); end
    total++; if (data_out !== 8'h81) begin bad++; $display("FAIL parity_bad_hold got=%h want=81", data_out); end
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clk(2 * BIT_CLK);
    total++; if (pcnt != 0) begin bad++; $display("FAIL parity_good_perr got=%0d want=0", pcnt); end
    total++; if (vq.size() != 1 || data_out !== 8'h07) begin bad++; $display("FAIL parity_good got=%0d/%h want=1/07", vq.size(), data_out); end
    clear_mon();
    send_frame(8'h07, 1'b0, 1'b0);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    total++; if (fcnt != 1 || pcnt != 0) begin bad++; $display("FAIL parity_priority got=%0d/%0d want=1/0", fcnt, pcnt); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    logic [7:0] d;
    logic       stop;
    logic       par;
    int         exp_f;
    int         exp_p;
    clear_mon();
    last_good = data_out;
    exp_f = 0;
    exp_p = 0;
    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = even_par(d);
`ifdef UART_RX_PARITY_EN
      if ($urandom_range(0, 3) == 0) par = ~par;
`endif
      send_frame(d, stop, par);
      if (!stop) exp_f++;
`ifdef UART_RX_PARITY_EN
      else if (par != even_par(d)) exp_p++;
`endif
      else begin
        exp_q.push_back(d);
        last_good = d;
      end
      rx = 1'b1;
      if (!stop) wait_clk(2 * BIT_CLK);
      else wait_clk($urandom_range(0, 80));
    end
    wait_clk(2 * BIT_CLK);
    total++; if (vq.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", vq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < vq.size(); i++) begin
      total++; if (vq[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h want=%h", i, vq[i], exp_q[i]); end
    end
    total++; if (fcnt != exp_f) begin bad++; $display("FAIL rand_ferr got=%0d want=%0d", fcnt, exp_f); end
    total++; if (pcnt != exp_p) begin bad++; $display("FAIL rand_perr got=%0d want=%0d", pcnt, exp_p); end
    total++; if (data_out !== last_good) begin bad++; $display("FAIL rand_hold got=%h want=%h", data_out, last_good); end
    total++; if (excl != 0) begin bad++; $display("FAIL pulse_exclusive got=%0d want=0", excl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
